// File: rtl/debounce_ctrl.sv
// Multi-channel input debouncer with a round-robin event arbiter.
// Each channel is synchronized and debounced; changes on enabled channels are queued and presented one at a time.
module debounce_ctrl #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  din,
    input  logic [N_CH-1:0]  en_mask,
    input  logic [CNT_W-1:0] stable_cnt,
    input  logic             ovf_clr,
    input  logic             evt_ready,
    output logic [N_CH-1:0]  deb_q,
    output logic             evt_valid,
    output logic [CH_W-1:0]  evt_ch,
    output logic             evt_pol,
    output logic [N_CH-1:0]  ovf
);
    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_PRESENT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [N_CH-1:0]  CH_ONE    = 1;
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [CH_W-1:0]  CH_INC    = 1;

    logic [N_CH-1:0]  r_sync1;
    logic [N_CH-1:0]  r_sync2;
    logic [N_CH-1:0]  r_deb;
    logic [N_CH-1:0]  r_pend;
    logic [N_CH-1:0]  r_ppol;
    logic [N_CH-1:0]  r_ovf;
    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [0:0]       r_state;
    logic [CH_W-1:0]  r_rr_ptr;
    logic [CH_W-1:0]  r_evt_ch;
    logic             r_evt_pol;

    logic [CNT_W-1:0] w_eff_m1;
    logic [CNT_W-1:0] w_cnt_next [N_CH];
    logic [N_CH-1:0]  w_chg;
    logic [N_CH-1:0]  w_new;
    logic [N_CH-1:0]  w_pend_next;
    logic [N_CH-1:0]  w_ppol_next;
    logic [N_CH-1:0]  w_ovf_next;
    logic [N_CH-1:0]  w_lo_mask;
    logic [N_CH-1:0]  w_hi_pend;
    logic [N_CH-1:0]  w_gnt_vec;
    logic [CH_W-1:0]  w_gnt_idx;
    logic [CH_W-1:0]  w_rr_next;
    logic             w_gnt;

    // A threshold of zero is treated as one cycle of stability.
    assign w_eff_m1 = (stable_cnt == '0) ? '0 : stable_cnt - CNT_ONE;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign w_chg[gi]       = (r_sync2[gi] != r_deb[gi]) && (r_cnt[gi] == w_eff_m1);
            assign w_cnt_next[gi]  = ((r_sync2[gi] == r_deb[gi]) || w_chg[gi]) ? '0 : r_cnt[gi] + CNT_ONE;
            assign w_new[gi]       = w_chg[gi] & en_mask[gi];
            // A fresh change beats a same-cycle grant, so the channel stays pending without overflow.
            assign w_pend_next[gi] = en_mask[gi] & (w_new[gi] | (r_pend[gi] & ~w_gnt_vec[gi]));
            assign w_ppol_next[gi] = w_new[gi] ? r_sync2[gi] : r_ppol[gi];
            assign w_ovf_next[gi]  = (r_ovf[gi] & ~ovf_clr) | (w_new[gi] & r_pend[gi] & ~w_gnt_vec[gi]);
        end
    endgenerate

    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    // Round robin: prefer pending channels at or above rr_ptr, otherwise wrap to the lowest.
    assign w_lo_mask = (CH_ONE << r_rr_ptr) - CH_ONE;
    assign w_hi_pend = r_pend & ~w_lo_mask;
    assign w_gnt_idx = (|w_hi_pend) ? lowest_set(w_hi_pend) : lowest_set(r_pend);
    assign w_gnt     = (r_state == S_IDLE) && (|r_pend);
    assign w_gnt_vec = w_gnt ? (CH_ONE << w_gnt_idx) : '0;
    assign w_rr_next = (r_evt_ch == CH_LAST) ? '0 : r_evt_ch + CH_INC;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_pend  <= '0;
            r_ppol  <= '0;
            r_ovf   <= '0;
            for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_deb   <= r_deb ^ w_chg;
            r_pend  <= w_pend_next;
            r_ppol  <= w_ppol_next;
            r_ovf   <= w_ovf_next;
            for (int i = 0; i < N_CH; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_evt_ch  <= '0;
            r_evt_pol <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt) begin
                        r_evt_ch  <= w_gnt_idx;
                        r_evt_pol <= r_ppol[w_gnt_idx];
                        r_state   <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (evt_ready) begin
                        r_rr_ptr <= w_rr_next;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign deb_q     = r_deb;
    assign ovf       = r_ovf;
    assign evt_valid = (r_state == S_PRESENT);
    assign evt_ch    = r_evt_ch;
    assign evt_pol   = r_evt_pol;
endmodule
